cd_spi2csr: RTL and testbench
=============================

Name: cd_spi2csr

Overview:
- SPI slave front end that initiates accesses on the CDBUS 5-bit-address, 8-bit-data CSR port (csr_address/csr_read/csr_readdata/csr_write/csr_writedata).
- An external host MCU reaches the controller registers over a 4-wire SPI link through this block.
- It oversamples SPI in the clk domain, decodes a command byte, and issues one-cycle csr_write/csr_read pulses.
- It drives chip_select so the register block's chip-select features (address auto-reset, RX page auto-release, INT_FLAG shift) work.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on spi_sclk, spi_mosi and spi_nss (minimum 2).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- spi_sclk  in  1  SPI clock, mode 0 (idles low, sample on rise, shift on fall). Frequency ≤ clk/8.
- spi_mosi  in  1  host-to-device data, MSB first.
- spi_nss  in  1  active-low slave select.
- spi_miso  out  1  device-to-host data, MSB first.
- spi_miso_oe  out  1  tristate enable for spi_miso.
- chip_select  out  1  registered ~nss_sync, to the register block.
- csr_address  out  5  register address, latched from the command byte.
- csr_read  out  1  one-cycle read strobe.
- csr_readdata  in  8  combinational read data, valid in the same cycle as csr_read.
- csr_write  out  1  one-cycle write strobe.
- csr_writedata  out  8  write data, valid while csr_write is high.

Behaviour:
- Reset values:
  - all outputs 0.
  - sclk synchronizer 0; nss synchronizer 1.
  - bit_cnt 0; rx_shift and tx_shift 0.
  - state IDLE.
- Edge detect: rise = sclk_sync & ~sclk_prev; fall = ~sclk_sync & sclk_prev. Both qualified by nss_sync==0.
- Command byte:
  - bit7 = 1 means write, 0 means read; bits[4:0] = address; bits[6:5] ignored.
  - Address is fixed for the whole transaction, with no auto-increment. Burst writes to TX and burst reads from RX therefore hit the same FIFO register.
- States:
  - IDLE: nss_sync high. Outputs spi_miso_oe=0, chip_select=0, bit_cnt=0. On nss_sync falling go to CMD.
  - CMD: 8 rising edges shift MOSI into rx_shift. On the 8th, latch csr_address and the rw bit, then go to WDATA or RDATA.
  - WDATA: each complete byte issues csr_write.
  - RDATA: each byte boundary prefetches the next byte via csr_read.
  - Any state: nss_sync high returns to IDLE next cycle and discards any partial byte (no strobe).
- Rising edge detected in cycle N:
  - rx_shift <= {rx_shift[6:0], mosi_sync}; bit_cnt++ (3-bit, wraps 7→0).
  - If this edge completes a byte (bit_cnt==7):
    - WDATA: csr_write=1 in cycle N+1 with csr_writedata = completed byte.
    - CMD with read, or RDATA: csr_read=1 in cycle N+1, and tx_shift <= csr_readdata at the end of N+1.
- Falling edge: tx_shift <<= 1 only if bit_cnt != 0. This keeps the byte just loaded at a boundary from being shifted.
- spi_miso = tx_shift[7] whenever nss_sync is low.
  - During CMD, tx_shift is 0, so MISO shows 0x00.
  - The first read byte reaches MISO by N+2, which is ≥2 clk before the next SCLK rise.
- Read side effect: every read burst issues one csr_read more than the bytes the host clocks out (prefetch). The host accounts for this; chip-select deassert resets the RX pointer in the register block.
- spi_miso_oe = ~nss_sync, registered.
- chip_select:
  - asserts 1 cycle after nss_sync falls, before any csr strobe is possible;
  - deasserts 1 cycle after nss_sync rises.
- csr_read and csr_write are never high together and never high for 2 consecutive cycles.
- Reset mid-transaction returns to the reset state. The rest of that SPI frame is ignored until the next nss falling edge.

Test Plan:
1. Write burst: nss low, bytes 0x95, 0xA5, 0x3C, nss high → exactly 2 csr_write pulses, addr 0x15, data 0xA5 then 0x3C; csr_read never asserted.
2. Read burst: bytes 0x12 + 2 dummy bytes; the model returns 0x5A then 0xC3 → MISO bytes 0x00, 0x5A, 0xC3; 3 csr_read pulses at addr 0x12; chip_select drops after nss high.
3. Abort: 0x96 then 4 data bits, then nss high → no csr_write, chip_select=0 within 1 cycle after nss_sync high. A following write of 0x96, 0x07 yields csr_write addr 0x16, data 0x07.
4. Command-only frames: 0x80 alone → no strobe; 0x00 alone → 1 csr_read at addr 0x00, MISO 0x00.
5. Max rate: SCLK = clk/8 read burst of 16 bytes with an incrementing model → all MISO bytes correct; strobes one cycle wide; spi_miso_oe=0 while nss high.
6. reset_n low for 2 cycles mid-write byte → all outputs 0. After release, the remaining SCLK edges of that frame produce no strobe; the next frame works normally.

Source files
------------

// File: rtl/cd_spi2csr.sv
// cd_spi2csr: SPI mode-0 slave that turns host frames into CDBUS CSR accesses.
// A command byte selects read/write and a fixed 5-bit address; following bytes
// are written, or read back with one-byte prefetch, on that address.
module cd_spi2csr #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  input  logic       spi_nss,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       chip_select,
  output logic [4:0] csr_address,
  output logic       csr_read,
  input  logic [7:0] csr_readdata,
  output logic       csr_write,
  output logic [7:0] csr_writedata
);

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sr, mosi_sr, nss_sr, fill_sr;
  logic       sclk_sync, mosi_sync, nss_sync, sclk_prev;
  logic       armed;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift, tx_shift;
  logic       rise, fall, byte_done;
  logic       write_fire, read_fire;

  assign sclk_sync = sclk_sr[SYNC_STAGES-1];
  assign mosi_sync = mosi_sr[SYNC_STAGES-1];
  assign nss_sync  = nss_sr[SYNC_STAGES-1];

  assign rise      = sclk_sync & ~sclk_prev & ~nss_sync;
  assign fall      = ~sclk_sync & sclk_prev & ~nss_sync;
  assign byte_done = rise & (bit_cnt == 3'd7);

  // MISO follows the top of the transmit shifter while selected
  always_comb begin
    spi_miso = ~nss_sync & tx_shift[7];
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state and strobe decode
  always_comb begin
    state_next = state;
    write_fire = 1'b0;
    read_fire  = 1'b0;
    unique case (state)
      // armed requires a genuine nss high after reset, so a frame already in
      // progress when reset was released is ignored until nss toggles.
      IDLE:  if (armed && !nss_sync) state_next = CMD;
      CMD:   if (byte_done) begin
               // rw bit (command bit 7) sits at rx_shift[6] on the 8th edge
               state_next = rx_shift[6] ? WDATA : RDATA;
               read_fire  = ~rx_shift[6];
             end
      WDATA: write_fire = byte_done;
      RDATA: read_fire  = byte_done;
      default: state_next = IDLE;
    endcase
    if (state != IDLE && nss_sync) begin
      state_next = IDLE;
      write_fire = 1'b0;
      read_fire  = 1'b0;
    end
  end

  // Synchronizers, shifters, and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sclk_sr       <= '0;
      mosi_sr       <= '0;
      nss_sr        <= '1;
      fill_sr       <= '0;
      sclk_prev     <= 1'b0;
      armed         <= 1'b0;
      bit_cnt       <= '0;
      rx_shift      <= '0;
      tx_shift      <= '0;
      spi_miso_oe   <= 1'b0;
      chip_select   <= 1'b0;
      csr_address   <= '0;
      csr_read      <= 1'b0;
      csr_write     <= 1'b0;
      csr_writedata <= '0;
    end else begin
      sclk_sr     <= {sclk_sr[SYNC_STAGES-2:0], spi_sclk};
      mosi_sr     <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi};
      nss_sr      <= {nss_sr[SYNC_STAGES-2:0], spi_nss};
      // fill_sr marks when the nss chain holds only post-reset samples
      fill_sr     <= {fill_sr[SYNC_STAGES-2:0], 1'b1};
      sclk_prev   <= sclk_sync;
      armed       <= armed | (fill_sr[SYNC_STAGES-1] & nss_sync);
      spi_miso_oe <= ~nss_sync;
      chip_select <= (state_next != IDLE);
      csr_write   <= write_fire;
      csr_read    <= read_fire;
      if (write_fire)
        csr_writedata <= {rx_shift[6:0], mosi_sync};
      if (state == CMD && byte_done)
        csr_address <= {rx_shift[3:0], mosi_sync};
      if (state_next == IDLE) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
        tx_shift <= '0;
      end else if (state != IDLE) begin
        if (rise) begin
          rx_shift <= {rx_shift[6:0], mosi_sync};
          bit_cnt  <= bit_cnt + 3'd1;
        end
        // A byte just loaded at a boundary must not be shifted by the
        // falling edge that follows the boundary rise (bit_cnt is 0 then).
        if (csr_read)
          tx_shift <= csr_readdata;
        else if (fall && bit_cnt != 3'd0)
          tx_shift <= {tx_shift[6:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_cd_spi2csr.sv
// Bench for cd_spi2csr: an SPI host drives frames, a frame-level model queues
// the expected CSR strobes, and a monitor checks strobes as they appear.
module tb_cd_spi2csr;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       spi_sclk, spi_mosi, spi_nss;
  logic       spi_miso, spi_miso_oe, chip_select;
  logic [4:0] csr_address;
  logic       csr_read, csr_write;
  logic [7:0] csr_readdata, csr_writedata;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic       w;
    logic [4:0] a;
    logic [7:0] d;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] rd_mem [0:255];
  logic [7:0] rd_ptr = 8'd0;
  int         model_idx = 0;
  logic [7:0] fb [0:31];
  logic [7:0] exp_miso [0:31];
  logic       prev_strobe = 1'b0;

  always #5 clk = ~clk;

  cd_spi2csr #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_nss(spi_nss),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .chip_select(chip_select),
    .csr_address(csr_address), .csr_read(csr_read), .csr_readdata(csr_readdata),
    .csr_write(csr_write), .csr_writedata(csr_writedata)
  );

  // Register-block stand-in: read data comes from rd_mem in read order
  assign csr_readdata = rd_mem[rd_ptr];
  always @(posedge clk) if (csr_read) rd_ptr <= rd_ptr + 8'd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: every strobe must match the head of the expectation queue
  always @(negedge clk) begin
    if (reset_n) begin
      if (csr_write || csr_read) begin
        check("strobe_excl", {31'd0, csr_write & csr_read}, 32'd0);
        check("strobe_width", {31'd0, prev_strobe}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe actual=w%0d/r%0d addr=0x%0h required=none",
                   csr_write, csr_read, csr_address);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("strobe_kind", {31'd0, csr_write}, {31'd0, e.w});
          check("strobe_addr", {27'd0, csr_address}, {27'd0, e.a});
          if (e.w) check("wdata", {24'd0, csr_writedata}, {24'd0, e.d});
        end
      end
      prev_strobe = csr_write | csr_read;
    end else begin
      prev_strobe = 1'b0;
    end
  end

  // Shift the top nbits of v MSB first; return what MISO showed at each rise
  task automatic spi_bits(input logic [7:0] v, input int nbits, input int half,
                          output logic [7:0] mi);
    logic [7:0] tmp;
    tmp = v;
    mi  = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tmp[7];
      tmp      = {tmp[6:0], 1'b0};
      repeat (half) @(negedge clk);
      spi_sclk = 1'b1;
      mi       = {mi[6:0], spi_miso};
      repeat (half) @(negedge clk);
      spi_sclk = 1'b0;
    end
  endtask

  // Frame-level model: one strobe per complete byte after (write) or
  // including (read) the command; read data appears on MISO one byte later.
  task automatic model_frame(input int nb);
    logic [7:0] cmd;
    for (int k = 0; k < 32; k++) exp_miso[k] = 8'h00;
    if (nb >= 1) begin
      cmd = fb[0];
      if (cmd[7]) begin
        for (int k = 1; k < nb; k++) exp_q.push_back('{w: 1'b1, a: cmd[4:0], d: fb[k]});
      end else begin
        for (int k = 0; k < nb; k++) begin
          exp_q.push_back('{w: 1'b0, a: cmd[4:0], d: 8'h00});
          if (k > 0) exp_miso[k] = rd_mem[(model_idx + k - 1) % 256];
        end
        model_idx += nb;
      end
    end
  endtask

  task automatic end_frame(input int half);
    repeat (half) @(negedge clk);
    spi_nss = 1'b1;
    repeat (3) @(negedge clk);
    check("cs_drop", {31'd0, chip_select}, 32'd0);
    check("oe_drop", {31'd0, spi_miso_oe}, 32'd0);
    repeat (8) @(negedge clk);
    check("strobes_pending", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  // nb full bytes from fb, then 'extra' bits of fb[nb], then deselect
  task automatic run_frame(input int nb, input int extra, input int half);
    logic [7:0] mi;
    model_frame(nb);
    @(negedge clk);
    spi_nss = 1'b0;
    repeat (3) @(negedge clk);
    check("cs_assert", {31'd0, chip_select}, 32'd1);
    check("oe_assert", {31'd0, spi_miso_oe}, 32'd1);
    repeat (half) @(negedge clk);
    for (int k = 0; k < nb; k++) begin
      spi_bits(fb[k], 8, half, mi);
      check($sformatf("miso_byte%0d", k), {24'd0, mi}, {24'd0, exp_miso[k]});
    end
    if (extra > 0) spi_bits(fb[nb], extra, half, mi);
    end_frame(half);
  endtask

  initial begin
    logic [7:0] mi;
    for (int i = 0; i < 256; i++) rd_mem[i] = 8'($urandom);
    reset_n  = 1'b0;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    spi_nss  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_outputs", {22'd0, spi_miso, spi_miso_oe, chip_select, csr_read, csr_write,
                          csr_address}, 32'd0);
    check("rst_wdata", {24'd0, csr_writedata}, 32'd0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    // Write burst
    fb[0] = 8'h95; fb[1] = 8'hA5; fb[2] = 8'h3C;
    run_frame(3, 0, 4);

    // Read burst with known prefetch data
    rd_mem[model_idx % 256]       = 8'h5A;
    rd_mem[(model_idx + 1) % 256] = 8'hC3;
    fb[0] = 8'h12; fb[1] = 8'hFF; fb[2] = 8'h00;
    run_frame(3, 0, 5);

    // Abort mid data byte, then a clean write to the same address
    fb[0] = 8'h96; fb[1] = 8'hB0;
    run_frame(1, 4, 4);
    fb[0] = 8'h96; fb[1] = 8'h07;
    run_frame(2, 0, 4);

    // Command-only frames
    fb[0] = 8'h80;
    run_frame(1, 0, 4);
    fb[0] = 8'h00;
    run_frame(1, 0, 4);

    // 16-byte read burst at the fastest SCLK with an incrementing source
    for (int i = 0; i < 256; i++) rd_mem[i] = 8'(i + 8'h21);
    fb[0] = 8'h0B;
    for (int k = 1; k < 16; k++) fb[k] = 8'($urandom);
    run_frame(16, 0, 4);

    // Reset mid write byte: remainder of the frame must produce nothing
    @(negedge clk);
    spi_nss = 1'b0;
    repeat (7) @(negedge clk);
    spi_bits(8'h9F, 8, 4, mi);
    spi_bits(8'hE1, 4, 4, mi);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_outputs", {22'd0, spi_miso, spi_miso_oe, chip_select, csr_read, csr_write,
                             csr_address}, 32'd0);
    check("midrst_wdata", {24'd0, csr_writedata}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    spi_bits(8'h10, 4, 4, mi);
    spi_bits(8'h77, 8, 4, mi);
    spi_bits(8'h88, 8, 4, mi);
    end_frame(4);
    repeat (4) @(negedge clk);
    fb[0] = 8'h8A; fb[1] = 8'h5E;
    run_frame(2, 0, 4);

    // Randomized frames, including aborted partial bytes
    for (int i = 0; i < 256; i++) rd_mem[i] = 8'($urandom);
    for (int t = 0; t < 24; t++) begin
      int nb, extra, half;
      nb    = int'($urandom_range(0, 5));
      extra = (nb == 0) ? int'($urandom_range(1, 7)) : int'($urandom_range(0, 7));
      half  = int'($urandom_range(4, 6));
      for (int k = 0; k <= nb; k++) fb[k] = 8'($urandom);
      run_frame(nb, extra, half);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
